// File: rtl/calc_pkg.sv
// Shared types and helpers for the sequential calculator: opcode and FSM
// encodings plus the active-low hex to seven-segment decoder.
package calc_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'd0,
        OP_OR  = 4'd1,
        OP_XOR = 4'd2,
        OP_ADD = 4'd3,
        OP_SUB = 4'd4,
        OP_SHL = 4'd5,
        OP_SHR = 4'd6,
        OP_ASR = 4'd7,
        OP_NOT = 4'd8,
        OP_MUL = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Active-low segment pattern, bit order gfedcba.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/calculadora_seq_seg_scan.sv
// Multiplexed seven-segment scanner: each digit of the magnitude is lit for
// REFRESH cycles in turn, digit 0 first after reset.
module seg_scan
    import calc_pkg::*;
#(
    parameter int N       = 8,
    parameter int DIGITS  = 2,
    parameter int REFRESH = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-2:0]      mag,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [RW-1:0]         tick_reg;
    logic [IW-1:0]         idx_reg;
    logic [4*DIGITS-1:0]   padded;
    logic [3:0]            nib;

    // Refresh divider and digit index; free-running, only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_reg <= '0;
            idx_reg  <= '0;
        end else if (tick_reg == RW'(REFRESH - 1)) begin
            tick_reg <= '0;
            idx_reg  <= (idx_reg == IW'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
        end else begin
            tick_reg <= tick_reg + 1'b1;
        end
    end

    // Zero-extend the magnitude to a whole number of nibbles.
    always_comb begin
        padded = '0;
        padded[N-2:0] = mag;
    end

    // Pick the nibble belonging to the currently lit digit.
    always_comb begin
        nib = padded[3:0];
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_reg == IW'(i)) begin
                nib = padded[4*i +: 4];
            end
        end
    end

    assign seg = hex7(nib);

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_an
            assign an[gi] = ~(idx_reg == IW'(gi));
        end
    endgenerate

endmodule

// File: rtl/calculadora_seq.sv
// Sequential calculator: start/busy/done handshake, accumulator chaining,
// shift-add multiplier, registered result/flags and sign-magnitude display.
module calculadora_seq
    import calc_pkg::*;
#(
    parameter  int N       = 8,
    parameter  int REFRESH = 50000,
    localparam int DIGITS  = (N + 2) / 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      a,
    input  logic [N-1:0]      b,
    input  logic [3:0]        sel,
    input  logic              use_acc,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [N-1:0]      result,
    output logic              Z,
    output logic              C,
    output logic              N_f,
    output logic              O,
    output logic              Sign,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int CW = $clog2(N + 1);

    state_e          state_reg;
    op_e             op_reg;
    logic [N-1:0]    op_a_reg;
    logic [N-1:0]    op_b_reg;
    logic [2*N-1:0]  mcand_reg;
    logic [2*N-1:0]  prod_reg;
    logic [CW-1:0]   mul_cnt_reg;
    logic [N-1:0]    result_reg;
    logic            z_reg, c_reg, n_reg, o_reg;
    logic [N-2:0]    mag_reg;
    logic            sign_reg;

    logic [N-1:0]    opa_sel;
    logic [N:0]      add_ext, sub_ext;
    logic [N-1:0]    alu_res;
    logic            alu_c, alu_o, alu_valid;

    assign opa_sel = use_acc ? result_reg : a;
    assign add_ext = {1'b0, op_a_reg} + {1'b0, op_b_reg};
    assign sub_ext = {1'b0, op_a_reg} - {1'b0, op_b_reg};

    // Single-cycle ALU; invalid opcodes (and MUL, handled elsewhere) leave
    // the result registers untouched.
    always_comb begin
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_o     = 1'b0;
        alu_valid = 1'b1;
        case (op_reg)
            OP_AND: alu_res = op_a_reg & op_b_reg;
            OP_OR:  alu_res = op_a_reg | op_b_reg;
            OP_XOR: alu_res = op_a_reg ^ op_b_reg;
            OP_ADD: begin
                alu_res = add_ext[N-1:0];
                alu_c   = add_ext[N];
                alu_o   = (op_a_reg[N-1] == op_b_reg[N-1]) && (alu_res[N-1] != op_a_reg[N-1]);
            end
            OP_SUB: begin
                alu_res = sub_ext[N-1:0];
                alu_c   = ~sub_ext[N];
                alu_o   = (op_a_reg[N-1] != op_b_reg[N-1]) && (alu_res[N-1] != op_a_reg[N-1]);
            end
            OP_SHL: begin
                alu_res = {op_a_reg[N-2:0], 1'b0};
                alu_c   = op_a_reg[N-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, op_a_reg[N-1:1]};
                alu_c   = op_a_reg[0];
            end
            OP_ASR: begin
                alu_res = {op_a_reg[N-1], op_a_reg[N-1:1]};
                alu_c   = op_a_reg[0];
            end
            OP_NOT: alu_res = ~op_a_reg;
            default: alu_valid = 1'b0;
        endcase
    end

    // Control FSM, operand latches, multiplier iterations and result write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= S_IDLE;
            op_reg      <= OP_AND;
            op_a_reg    <= '0;
            op_b_reg    <= '0;
            mcand_reg   <= '0;
            prod_reg    <= '0;
            mul_cnt_reg <= '0;
            result_reg  <= '0;
            z_reg       <= 1'b0;
            c_reg       <= 1'b0;
            n_reg       <= 1'b0;
            o_reg       <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        op_a_reg    <= opa_sel;
                        op_b_reg    <= b;
                        op_reg      <= op_e'(sel);
                        mcand_reg   <= {{N{1'b0}}, opa_sel};
                        prod_reg    <= '0;
                        mul_cnt_reg <= '0;
                        state_reg   <= (sel == OP_MUL) ? S_MUL : S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (alu_valid) begin
                        result_reg <= alu_res;
                        z_reg      <= (alu_res == '0);
                        c_reg      <= alu_c;
                        n_reg      <= alu_res[N-1];
                        o_reg      <= alu_o;
                    end
                    state_reg <= S_DONE;
                end
                S_MUL: begin
                    if (mul_cnt_reg == CW'(N)) begin
                        // All N multiplier bits consumed: commit the low half.
                        result_reg <= prod_reg[N-1:0];
                        z_reg      <= (prod_reg[N-1:0] == '0);
                        c_reg      <= |prod_reg[2*N-1:N];
                        n_reg      <= prod_reg[N-1];
                        o_reg      <= |prod_reg[2*N-1:N];
                        state_reg  <= S_DONE;
                    end else begin
                        if (op_b_reg[0]) begin
                            prod_reg <= prod_reg + mcand_reg;
                        end
                        mcand_reg   <= mcand_reg << 1;
                        op_b_reg    <= op_b_reg >> 1;
                        mul_cnt_reg <= mul_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Display magnitude lags the result by one cycle; only the low N-1 bits
    // are shown, so the most-negative value wraps to all zeros with a minus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mag_reg  <= '0;
            sign_reg <= 1'b1;
        end else begin
            mag_reg  <= result_reg[N-1] ? (~result_reg[N-2:0] + 1'b1) : result_reg[N-2:0];
            sign_reg <= ~result_reg[N-1];
        end
    end

    seg_scan #(
        .N       (N),
        .DIGITS  (DIGITS),
        .REFRESH (REFRESH)
    ) u_scan (
        .clk (clk),
        .rst (rst),
        .mag (mag_reg),
        .seg (seg),
        .an  (an)
    );

    assign busy   = (state_reg != S_IDLE);
    assign done   = (state_reg == S_DONE);
    assign result = result_reg;
    assign Z      = z_reg;
    assign C      = c_reg;
    assign N_f    = n_reg;
    assign O      = o_reg;
    assign Sign   = sign_reg;

endmodule
